// File: rtl/bus_pkg.sv
// Shared constants for the CPU datapath bus arbiter: source select codes,
// source count, select width and FSM state encoding.
package bus_pkg;

  localparam int unsigned NUM_SRC = 24;
  localparam int unsigned SEL_W   = 5;

  localparam logic [4:0] SRC_R0     = 5'd0;
  localparam logic [4:0] SRC_R1     = 5'd1;
  localparam logic [4:0] SRC_R2     = 5'd2;
  localparam logic [4:0] SRC_R3     = 5'd3;
  localparam logic [4:0] SRC_R4     = 5'd4;
  localparam logic [4:0] SRC_R5     = 5'd5;
  localparam logic [4:0] SRC_R6     = 5'd6;
  localparam logic [4:0] SRC_R7     = 5'd7;
  localparam logic [4:0] SRC_R8     = 5'd8;
  localparam logic [4:0] SRC_R9     = 5'd9;
  localparam logic [4:0] SRC_R10    = 5'd10;
  localparam logic [4:0] SRC_R11    = 5'd11;
  localparam logic [4:0] SRC_R12    = 5'd12;
  localparam logic [4:0] SRC_R13    = 5'd13;
  localparam logic [4:0] SRC_R14    = 5'd14;
  localparam logic [4:0] SRC_R15    = 5'd15;
  localparam logic [4:0] SRC_HI     = 5'd16;
  localparam logic [4:0] SRC_LO     = 5'd17;
  localparam logic [4:0] SRC_ZHI    = 5'd18;
  localparam logic [4:0] SRC_ZLOW   = 5'd19;
  localparam logic [4:0] SRC_PC     = 5'd20;
  localparam logic [4:0] SRC_MDR    = 5'd21;
  localparam logic [4:0] SRC_INPORT = 5'd22;
  localparam logic [4:0] SRC_CSIGN  = 5'd23;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_GRANT      = 2'd1;
  localparam logic [1:0] ST_TURNAROUND = 2'd2;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: first requester after 'last', wrapping
// from NUM_SRC-1 back to 0.
module rr_priority_picker #(
  parameter int unsigned NUM_SRC = 24
) (
  input  logic [NUM_SRC-1:0]         req,
  input  logic [bus_pkg::SEL_W-1:0]  last,
  output logic                       found,
  output logic [bus_pkg::SEL_W-1:0]  index
);
  import bus_pkg::*;

  // Two ascending passes: indices above last first, then the wrapped part.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int unsigned j = 0; j < NUM_SRC; j++) begin
      if (!found && req[j] && (j > 32'(last))) begin
        found = 1'b1;
        index = SEL_W'(j);
      end
    end
    for (int unsigned j = 0; j < NUM_SRC; j++) begin
      if (!found && req[j] && (j <= 32'(last))) begin
        found = 1'b1;
        index = SEL_W'(j);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared datapath bus with a hold limit and a
// mandatory one-cycle turnaround between drivers.
module bus_arbiter #(
  parameter int unsigned NUM_SRC  = 24,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                       clock,
  input  logic                       clear,
  input  logic [NUM_SRC-1:0]         req,
  output logic [NUM_SRC-1:0]         grant,
  output logic [bus_pkg::SEL_W-1:0]  bus_select,
  output logic                       bus_valid,
  output logic                       hold_timeout
);
  import bus_pkg::*;

  logic [1:0]         state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               valid_q, valid_d;
  logic               tmo_q, tmo_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [SEL_W-1:0]   last_q, last_d;

  logic               pick_found;
  logic [SEL_W-1:0]   pick_index;
  logic               held_req;

  rr_priority_picker #(
    .NUM_SRC (NUM_SRC)
  ) u_picker (
    .req   (req),
    .last  (last_q),
    .found (pick_found),
    .index (pick_index)
  );

  assign held_req = |(req & grant_q);

  always_comb begin
    state_d = state_q;
    grant_d = '0;
    sel_d   = '0;
    valid_d = 1'b0;
    tmo_d   = 1'b0;
    cnt_d   = cnt_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE, ST_TURNAROUND: begin
        if (pick_found) begin
          state_d = ST_GRANT;
          grant_d = NUM_SRC'(1) << pick_index;
          sel_d   = pick_index;
          valid_d = 1'b1;
          cnt_d   = 4'd1;
          last_d  = pick_index;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        // A dropped request wins over the limit, so no pulse on a normal release.
        if (!held_req) begin
          state_d = ST_TURNAROUND;
          cnt_d   = '0;
        end else if (cnt_q == 4'(MAX_HOLD)) begin
          state_d = ST_TURNAROUND;
          tmo_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          grant_d = grant_q;
          sel_d   = sel_q;
          valid_d = 1'b1;
          cnt_d   = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
      last_q  <= SEL_W'(NUM_SRC - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign grant        = grant_q;
  assign bus_select   = sel_q;
  assign bus_valid    = valid_q;
  assign hold_timeout = tmo_q;

endmodule
